muldiv_unit: RTL

Iterative RV32M multiply/divide unit; the responder on the execute-stage request interface. The core control issues a request carrying the funct3-coded M operation and two operands. The unit stalls the core via req_ready and returns one 32-bit result per request over a valid/ready response channel. It sits beside the single-cycle ALU; the core's writeback mux selects between the two.

---
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply/divide responder for the execute stage.
//
// One request at a time. Multiply is radix-2 shift-add on operand magnitudes.
// Divide is restoring division on magnitudes. Both run 32 iterations, one per
// cycle, and apply the sign correction on the last one. Divide-by-zero and
// signed overflow (0x80000000 / -1) skip the iterations and complete directly.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous abort, drops any in-flight operation
//   req_valid/req_ready, req_op (funct3), data1 (rs1), data2 (rs2)
//   resp_valid/resp_ready, outputData (result, held while resp_valid)
//   busy          high while an operation is in flight or awaiting handshake
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] outputData,
   output logic            busy
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

   state_e              state_q;
   logic [5:0]          cnt_q;
   logic [2:0]          op_q;
   logic                neg_q;
   logic [XLEN-1:0]     a_q;      // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]   prod_q;   // {acc, multiplier} or {remainder, quotient}
   logic [XLEN-1:0]     out_q;
   logic                req_ready_q, resp_valid_q, busy_q;

   // ---------------- request decode ----------------
   logic            sgn1, sgn2, neg1, neg2, is_div, div0, ovf, special, acc_neg;
   logic [XLEN-1:0] mag1, mag2, spec_res;

   always_comb begin
      // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 additionally not for MULHSU
      sgn1     = (req_op != 3'd3) && (req_op != 3'd5) && (req_op != 3'd7);
      sgn2     = sgn1 && (req_op != 3'd2);
      neg1     = sgn1 && data1[XLEN-1];
      neg2     = sgn2 && data2[XLEN-1];
      mag1     = neg1 ? -data1 : data1;
      mag2     = neg2 ? -data2 : data2;
      is_div   = req_op[2];
      div0     = is_div && (data2 == '0);
      ovf      = is_div && !req_op[0] && (data1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (data2 == '1);
      special  = div0 || ovf;
      // req_op[1] selects REM/REMU within the divide group
      spec_res = '0;
      if (div0)     spec_res = req_op[1] ? data1 : '1;
      else if (ovf) spec_res = req_op[1] ? '0 : data1;
      // remainder follows the dividend sign; everything else is sign XOR
      acc_neg  = (is_div && req_op[1]) ? neg1 : (neg1 ^ neg2);
   end

   // ---------------- one iteration ----------------
   logic [XLEN:0]     mul_sum, div_sh;
   logic [XLEN-1:0]   div_dif;
   logic              div_ge;
   logic [2*XLEN-1:0] iter_nxt, mneg;
   logic [XLEN-1:0]   res;

   always_comb begin
      mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
      // shift the partial remainder left, pulling in the next dividend bit
      div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
      div_ge   = div_sh >= {1'b0, a_q};
      div_dif  = div_sh[XLEN-1:0] - a_q;
      if (op_q[2])
         iter_nxt = {(div_ge ? div_dif : div_sh[XLEN-1:0]), prod_q[XLEN-2:0], div_ge};
      else
         iter_nxt = {mul_sum, prod_q[XLEN-1:1]};
      mneg = neg_q ? -iter_nxt : iter_nxt;
      // quotient and remainder are corrected separately: a 64-bit negate
      // would carry from the quotient half into the remainder half
      case (op_q)
         3'd0:       res = mneg[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:       res = mneg[2*XLEN-1:XLEN];
         3'd4, 3'd5: res = neg_q ? -iter_nxt[XLEN-1:0] : iter_nxt[XLEN-1:0];
         default:    res = neg_q ? -iter_nxt[2*XLEN-1:XLEN] : iter_nxt[2*XLEN-1:XLEN];
      endcase
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         neg_q        <= 1'b0;
         a_q          <= '0;
         prod_q       <= '0;
         out_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else if (flush) begin
         // abort wins over accept and over the response handshake
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q        <= req_op;
                  cnt_q       <= '0;
                  busy_q      <= 1'b1;
                  req_ready_q <= 1'b0;
                  if (special) begin
                     out_q        <= spec_res;
                     resp_valid_q <= 1'b1;
                     state_q      <= S_DONE;
                  end else begin
                     neg_q   <= acc_neg;
                     a_q     <= is_div ? mag2 : mag1;
                     prod_q  <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                     state_q <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               prod_q <= iter_nxt;
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == LAST_ITER) begin
                  out_q        <= res;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_DONE;
               end
            end
            S_DONE: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign outputData = out_q;
   assign busy       = busy_q;

endmodule
